alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
- Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU as stable registered operands.
- Captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Aborts a partial transaction on inter-byte timeout.

Parameters:
- N_BITS, 8, data width of UART bytes, ALU operands and result.
- N_BITS_OP, 6, opcode width; must be <= N_BITS.
- TIMEOUT_CYCLES, 1000000, max clock cycles allowed between bytes of one transaction; 0 disables timeout.
- CNT_BITS, 32, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  N_BITS  byte from UART receiver, valid when i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse: new received byte.
- i_alu_result  input  N_BITS  combinational result from ALU.
- i_tx_done  input  1  one-cycle pulse: transmitter finished sending the byte.
- o_data1  output  N_BITS  operand A to ALU (registered).
- o_data2  output  N_BITS  operand B to ALU (registered).
- o_operator  output  N_BITS_OP  opcode to ALU (registered).
- o_tx_data  output  N_BITS  result byte to transmitter (registered).
- o_tx_start  output  1  one-cycle pulse: start transmission of o_tx_data.
- o_busy  output  1  high from opcode capture until i_tx_done.
- o_timeout  output  1  one-cycle pulse: transaction aborted on timeout.

Behaviour:
- Reset (async assert, sync release): state=WAIT_A, counter=0. All outputs are 0.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- WAIT_A:
  - On i_rx_done: o_data1<=i_rx_data, go to WAIT_B, counter<=0.
  - This state has no timeout.
- WAIT_B:
  - On i_rx_done: o_data2<=i_rx_data, go to WAIT_OP, counter<=0.
- WAIT_OP:
  - On i_rx_done: o_operator<=i_rx_data[N_BITS_OP-1:0], go to COMPUTE.
  - Upper opcode byte bits are discarded.
- Timeout (WAIT_B, WAIT_OP only, TIMEOUT_CYCLES>0):
  - Counter increments each cycle without i_rx_done.
  - When counter reaches TIMEOUT_CYCLES-1 with no i_rx_done that cycle: go to WAIT_A, pulse o_timeout for 1 cycle, counter<=0.
  - o_data1/o_data2/o_operator keep their last values.
  - If i_rx_done coincides with the timeout cycle, the byte wins and no timeout fires.
- COMPUTE (1 cycle): o_tx_data<=i_alu_result, go to SEND.
  - Operands are already stable from the previous edge, so the ALU result is settled.
- SEND (1 cycle): o_tx_start=1, go to WAIT_TX.
- WAIT_TX:
  - o_tx_start=0.
  - On i_tx_done: go to WAIT_A.
  - No timeout in this state.
- o_busy=1 in COMPUTE, SEND and WAIT_TX; 0 otherwise.
- Latency: opcode i_rx_done sampled at edge k gives:
  - o_operator valid after edge k;
  - o_tx_data valid after edge k+1;
  - o_tx_start high between edges k+2 and k+3.
- i_rx_done in COMPUTE/SEND/WAIT_TX: byte is dropped, with no state or register change. The next transaction starts only with a byte received in WAIT_A.
- i_tx_done outside WAIT_TX: ignored.
- Operands and opcode hold their values until overwritten by the next transaction, so the ALU output stays stable between transactions.
- Reset asserted mid-transaction:
  - Immediately returns to WAIT_A and clears all outputs.
  - Clears any pending o_tx_start.
- Opcode values are passed through unchecked. Unsupported opcodes yield whatever the ALU returns (0 for its default case), which is still transmitted.

Test Plan:
- Reset, then rx 0x05, 0x03, 0x20 (ADD) -> o_data1=0x05, o_data2=0x03, o_operator=0x20; o_tx_data=0x08; single o_tx_start pulse exactly 2 cycles after the opcode capture edge; o_busy until i_tx_done.
- rx 0x03, 0x05, 0xE2 -> o_operator=0x22 (SUB, upper bits dropped); o_tx_data=0xFE.
- TIMEOUT_CYCLES=16: rx 0x11, then no byte for 16 cycles -> o_timeout pulses once, state WAIT_A. Then rx 0xAA, 0x0F, 0x24 (AND) -> o_tx_data=0x0A.
- In WAIT_TX, inject rx 0x77 before i_tx_done -> byte ignored, o_data1 unchanged. After i_tx_done, rx 0x01, 0x02, 0x25 (OR) -> o_tx_data=0x03.
- After rx 0x05, 0x03, assert i_rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, rx 0x20 is treated as operand A (o_data1=0x20), not as an opcode.
- Unknown opcode 0x3F with operands 0x12, 0x34 -> o_tx_data=0x00, o_tx_start still pulses once.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Sequencer between the UART rx/tx and a combinational ALU: gathers operand A,
// operand B and opcode bytes, then hands the ALU result to the transmitter.
module alu_uart_interface #(
    parameter int N_BITS         = 8,
    parameter int N_BITS_OP      = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_BITS       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_BITS-1:0]    i_rx_data,
    input  logic                 i_rx_done,
    input  logic [N_BITS-1:0]    i_alu_result,
    input  logic                 i_tx_done,
    output logic [N_BITS-1:0]    o_data1,
    output logic [N_BITS-1:0]    o_data2,
    output logic [N_BITS_OP-1:0] o_operator,
    output logic [N_BITS-1:0]    o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX
    } state_t;

    localparam bit                TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_BITS-1:0] CNT_LAST =
        CNT_BITS'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                state, state_nx;
    logic [CNT_BITS-1:0]   cnt, cnt_nx;
    logic [N_BITS-1:0]     data1_nx, data2_nx, tx_data_nx;
    logic [N_BITS_OP-1:0]  operator_nx;
    logic                  tx_start_nx, busy_nx, timeout_nx;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        data1_nx    = o_data1;
        data2_nx    = o_data2;
        operator_nx = o_operator;
        tx_data_nx  = o_tx_data;
        tx_start_nx = 1'b0;
        timeout_nx  = 1'b0;
        case (state)
            WAIT_A: begin
                if (i_rx_done) begin
                    data1_nx = i_rx_data;
                    state_nx = WAIT_B;
                    cnt_nx   = '0;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    data2_nx = i_rx_data;
                    state_nx = WAIT_OP;
                    cnt_nx   = '0;
                end else if (TO_EN && cnt == CNT_LAST) begin
                    state_nx   = WAIT_A;
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                end else if (TO_EN) begin
                    cnt_nx = cnt + CNT_BITS'(1);
                end
            end
            WAIT_OP: begin
                // A byte arriving on the last allowed cycle beats the timeout.
                if (i_rx_done) begin
                    operator_nx = i_rx_data[N_BITS_OP-1:0];
                    state_nx    = COMPUTE;
                    cnt_nx      = '0;
                end else if (TO_EN && cnt == CNT_LAST) begin
                    state_nx   = WAIT_A;
                    timeout_nx = 1'b1;
                    cnt_nx     = '0;
                end else if (TO_EN) begin
                    cnt_nx = cnt + CNT_BITS'(1);
                end
            end
            COMPUTE: begin
                // Operands were registered last edge, so the ALU output has settled.
                tx_data_nx = i_alu_result;
                state_nx   = SEND;
            end
            SEND: begin
                tx_start_nx = 1'b1;
                state_nx    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) state_nx = WAIT_A;
            end
            default: state_nx = WAIT_A;
        endcase
        busy_nx = (state_nx == COMPUTE) || (state_nx == SEND) || (state_nx == WAIT_TX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= WAIT_A;
            cnt        <= '0;
            o_data1    <= '0;
            o_data2    <= '0;
            o_operator <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            o_data1    <= data1_nx;
            o_data2    <= data2_nx;
            o_operator <= operator_nx;
            o_tx_data  <= tx_data_nx;
            o_tx_start <= tx_start_nx;
            o_busy     <= busy_nx;
            o_timeout  <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface: table of full transactions plus
// hand sequences for timeout, dropped bytes and mid-transaction reset.
module tb_alu_uart_interface;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic [7:0] alu_result;
    logic       tx_done = 1'b0;
    logic [7:0] data1, data2, tx_data;
    logic [5:0] operator;
    logic       tx_start, busy, timeout;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int to_cnt = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(
        .N_BITS(8), .N_BITS_OP(6), .TIMEOUT_CYCLES(16), .CNT_BITS(32)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_result), .i_tx_done(tx_done),
        .o_data1(data1), .o_data2(data2), .o_operator(operator),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy), .o_timeout(timeout)
    );

    // Environment ALU: the block under test only sequences, the ALU sits outside.
    always_comb begin
        case (operator)
            6'h20:   alu_result = data1 + data2;
            6'h22:   alu_result = data1 - data2;
            6'h24:   alu_result = data1 & data2;
            6'h25:   alu_result = data1 | data2;
            6'h26:   alu_result = data1 ^ data2;
            6'h27:   alu_result = ~(data1 | data2);
            default: alu_result = 8'h00;
        endcase
    end

    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (timeout)  to_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Entered at the negedge right after the opcode capture edge k.
    task automatic finish_txn(input logic [7:0] exp_d1, input logic [5:0] exp_op,
                              input logic [7:0] exp_res, input bit inject);
        int s0;
        s0 = start_cnt;
        chk("operator", operator, exp_op);
        chk("busy_compute", busy, 1);
        @(negedge clk);
        chk("tx_data", tx_data, exp_res);
        chk("tx_start_early", tx_start, 0);
        @(negedge clk);
        chk("tx_start_pulse", tx_start, 1);
        @(negedge clk);
        chk("tx_start_drop", tx_start, 0);
        chk("busy_wait_tx", busy, 1);
        if (inject) begin
            send_byte(8'h77);
            @(negedge clk);
            chk("drop_data1", data1, exp_d1);
            chk("drop_busy", busy, 1);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("busy_released", busy, 0);
        @(negedge clk);
        chk("start_pulses", start_cnt - s0, 1);
    endtask

    typedef struct {
        logic [7:0] a, b, op;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 6'h20, exp_res: 8'h08};
        vecs[1] = '{a: 8'h03, b: 8'h05, op: 8'hE2, exp_op: 6'h22, exp_res: 8'hFE};
        vecs[2] = '{a: 8'h12, b: 8'h34, op: 8'h3F, exp_op: 6'h3F, exp_res: 8'h00};
        vecs[3] = '{a: 8'h0F, b: 8'hF0, op: 8'h66, exp_op: 6'h26, exp_res: 8'hFF};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {data1, data2, operator, tx_data, tx_start, busy, timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            chk("data1", data1, vecs[i].a);
            chk("data2", data2, vecs[i].b);
            send_byte(vecs[i].op);
            finish_txn(vecs[i].a, vecs[i].exp_op, vecs[i].exp_res, 1'b0);
        end

        // Timeout after operand A: 16 idle edges, then one pulse.
        send_byte(8'h11);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout && n < 40);
        chk("timeout_latency", n, 16);
        chk("timeout_data1_kept", data1, 8'h11);
        chk("timeout_busy", busy, 0);
        @(negedge clk);
        chk("timeout_one_cycle", timeout, 0);
        send_byte(8'hAA);
        send_byte(8'h0F);
        send_byte(8'h24);
        finish_txn(8'hAA, 6'h24, 8'h0A, 1'b0);
        chk("timeout_count", to_cnt, 1);

        // Byte landing on the last allowed cycle beats the timeout.
        send_byte(8'h0A);
        repeat (15) @(negedge clk);
        send_byte(8'h50);
        chk("late_byte_data2", data2, 8'h50);
        send_byte(8'h26);
        finish_txn(8'h0A, 6'h26, 8'h5A, 1'b0);
        chk("late_byte_no_timeout", to_cnt, 1);

        // Byte received in WAIT_TX is dropped.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h25);
        finish_txn(8'h01, 6'h25, 8'h03, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h25);
        finish_txn(8'h01, 6'h25, 8'h03, 1'b0);

        // Asynchronous reset mid-transaction.
        send_byte(8'h05);
        send_byte(8'h03);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs",
               {data1, data2, operator, tx_data, tx_start, busy, timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h20);
        chk("post_reset_data1", data1, 8'h20);
        chk("post_reset_operator", operator, 0);
        chk("post_reset_busy", busy, 0);
        send_byte(8'h03);
        send_byte(8'h20);
        finish_txn(8'h20, 6'h20, 8'h23, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
